// File: rtl/rcn_pkg.sv
// Shared rcn word definitions used as defaults by the rcn FIFO blocks.
package rcn_pkg;

    localparam int RCN_WIDTH     = 69;
    localparam int RCN_VALID_BIT = RCN_WIDTH - 1;

    function automatic bit fifo_params_ok(input int width, input int depth_log2,
                                          input int afull_level);
        return (width >= 2) && (depth_log2 >= 1) && (depth_log2 <= 10) &&
               (afull_level >= 1) && (afull_level <= (1 << depth_log2));
    endfunction

endpackage

// File: rtl/rcn_fifo_mem.sv
// FIFO storage: synchronous write, asynchronous read, contents not reset.
module rcn_fifo_mem #(
    parameter int DATA_W = 68,
    parameter int ADDR_W = 4
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rcn_fifo_sync_param.sv
// First-word-fall-through synchronous FIFO for rcn words with sticky overflow flag.
module rcn_fifo_sync_param
    import rcn_pkg::*;
#(
    parameter int WIDTH       = RCN_WIDTH,
    parameter int DEPTH_LOG2  = 4,
    parameter int AFULL_LEVEL = (2 ** DEPTH_LOG2) - 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      rcn_in,
    input  logic                  push,
    output logic                  full,
    output logic                  afull,
    output logic [WIDTH-1:0]      rcn_out,
    input  logic                  pop,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  ovf,
    input  logic                  ovf_clr
);

    localparam int PTR_W  = DEPTH_LOG2 + 1;
    localparam int DATA_W = WIDTH - 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] AFULL_CNT = PTR_W'(AFULL_LEVEL);

    if (!fifo_params_ok(WIDTH, DEPTH_LOG2, AFULL_LEVEL)) begin : g_bad_params
        $error("rcn_fifo_sync_param: illegal WIDTH/DEPTH_LOG2/AFULL_LEVEL");
    end

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;
    logic              full_w, empty_w, push_valid, wr_en, rd_en;
    logic [DATA_W-1:0] head_data;

    // Handshake: a push is taken when rcn_in carries its valid bit and the FIFO was
    // not full before the edge; a pop is taken when it was not empty before the edge.
    // Neither decision looks at the other request, so push/pop never cross-enable.
    assign full_w  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                     (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
    assign empty_w = (wr_ptr_q == rd_ptr_q);

    assign push_valid = push & rcn_in[WIDTH-1];
    assign wr_en      = push_valid & ~full_w;
    assign rd_en      = pop & ~empty_w;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase
        if (ovf_clr) ovf_d = 1'b0;
        // A refused push wins over a same-cycle clear.
        if (push_valid & full_w) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    rcn_fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wdata_i (rcn_in[DATA_W-1:0]),
        .raddr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rdata_o (head_data)
    );

    assign full    = full_w;
    assign empty   = empty_w;
    assign afull   = (count_q >= AFULL_CNT);
    assign count   = count_q;
    assign ovf     = ovf_q;
    assign rcn_out = {~empty_w, head_data};

endmodule

// File: doc/rcn_fifo_sync_param.md
RCN_FIFO_SYNC_PARAM -- requirements
Module: rcn_fifo_sync_param

Interface
REQ-001 SHALL have parameter WIDTH, default 69, total rcn word width; bit WIDTH-1 is the valid flag.
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, giving storage depth DEPTH = 2**DEPTH_LOG2 entries; legal range 1..10.
REQ-003 SHALL have parameter AFULL_LEVEL, default DEPTH-2, the occupancy at or above which afull asserts; legal range 1..DEPTH.
REQ-004 SHALL have port clk, input, 1 bit, single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port rcn_in, input, WIDTH bits, incoming rcn word.
REQ-007 SHALL have port push, input, 1 bit, write request.
REQ-008 SHALL have port full, output, 1 bit, asserted when occupancy equals DEPTH.
REQ-009 SHALL have port afull, output, 1 bit, asserted when occupancy is at least AFULL_LEVEL.
REQ-010 SHALL have port rcn_out, output, WIDTH bits, {!empty, payload at head}.
REQ-011 SHALL have port pop, input, 1 bit, read request.
REQ-012 SHALL have port empty, output, 1 bit, asserted when occupancy is 0.
REQ-013 SHALL have port count, output, DEPTH_LOG2+1 bits, current occupancy.
REQ-014 SHALL have port ovf, output, 1 bit, sticky overflow flag.
REQ-015 SHALL have port ovf_clr, input, 1 bit, synchronous clear of ovf.

Function
REQ-016 SHALL use pointers of DEPTH_LOG2+1 bits (wrap bit included) so all DEPTH entries are usable; full = (MSBs differ, LSBs equal); empty = (pointers equal).
REQ-017 SHALL accept a write when push & rcn_in[WIDTH-1] & !full, storing rcn_in[WIDTH-2:0] at wr_ptr and incrementing wr_ptr modulo 2*DEPTH.
REQ-018 SHALL silently discard push with rcn_in[WIDTH-1]=0; no pointer, count or ovf change.
REQ-019 SHALL accept a read when pop & !empty, incrementing rd_ptr; pop while empty has no effect.
REQ-020 SHALL be first-word-fall-through: rcn_out payload reflects mem[rd_ptr] combinationally; a write becomes visible on rcn_out in the cycle after the accepting edge.
REQ-021 SHALL evaluate full and empty from registered state only: push while full is refused even with a simultaneous accepted pop; pop while empty is refused even with a simultaneous accepted push.
REQ-022 SHALL update count as a register: +1 on write only, -1 on read only, unchanged on both or neither; count always equals wr_ptr - rd_ptr.
REQ-023 SHALL derive full, afull and empty from registered count/pointers with no combinational path from push or pop.
REQ-024 SHALL set ovf on the edge following a refused valid push (push & valid & full); ovf_clr clears it; a simultaneous set and clear leaves ovf set.
REQ-025 SHALL keep rcn_out[WIDTH-1] = 0 whenever empty, regardless of stale memory contents.

Reset
REQ-026 SHALL asynchronously clear wr_ptr, rd_ptr, count and ovf when rst_n is low; outputs are then empty=1, full=0, afull=0, count=0, ovf=0, rcn_out valid bit 0.
REQ-027 SHALL not reset storage memory; reset mid-operation discards all entries.
REQ-028 SHALL release from reset synchronously with clk; the first accepted write is on the first rising edge with rst_n high.

Structure
REQ-029 SHALL take the rcn word width (69) and valid bit index (68) from the shared package rcn_pkg as defaults.
REQ-030 SHALL place storage in sub-module rcn_fifo_mem (synchronous write, asynchronous read, DEPTH x (WIDTH-1)).
REQ-031 SHALL reject illegal parameter values with an elaboration-time error.

Verification
REQ-032 Reset then 16 valid pushes (defaults) -> full=1 after the 16th edge, count=16, afull=1 from count=14, a 17th push sets ovf=1 and leaves the data unchanged.
REQ-033 Push words 0x1..0x5 then pop 5 -> rcn_out payload 0x1..0x5 in order, then empty=1 and rcn_out[68]=0.
REQ-034 Fill to 16, then push+pop together -> pop accepted, push refused, count=15, ovf=1; ovf_clr -> ovf=0.
REQ-035 Empty FIFO, push+pop together -> push accepted, count=1, rcn_out shows the word next cycle.
REQ-036 Push with rcn_in[68]=0 -> count stays 0, ovf stays 0; 40 push/pop cycles exercise pointer wrap with intact ordering.
REQ-037 Assert rst_n low with 7 entries held -> count=0, empty=1 immediately, without waiting for a clk edge.
